// File: rtl/pipreg_stage_elastic.sv
// Elastic pipeline stage register: PC, write address, data word and a
// control vector travel together as one beat. An optional second (skid)
// entry lets in_ready come straight from registered state. A global freeze
// (stall) stops both sides, flush kills every buffered beat, and two
// saturating counters report bubble and stall cycles.
//
// Handshake: a beat moves on the input side when in_valid & in_ready, and
// on the output side when out_valid & out_ready & !stall. A producer holds
// its beat stable until it is accepted. out_valid is never withdrawn except
// by flush or reset.
module pipreg_stage_elastic #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CTRL_W  = 3,
  parameter int RFW_BIT = 1,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_rf_write,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PW = 2 * DATA_W + ADDR_W + CTRL_W;

  // Occupancy: how many beats the stage holds. TWO is only reachable with
  // the skid entry present.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] h_q;      // head entry, drives the outputs
  logic [PW-1:0] s_q;      // skid entry, second-oldest beat
  logic [PW-1:0] in_beat;
  logic          accept;
  logic          retire;

  // Control bits sit in the low end of the packed beat, so the write-enable
  // bit is addressable directly as h_q[RFW_BIT].
  assign in_beat = {in_pc, in_waddr, in_data, in_ctrl};
  assign {out_pc, out_waddr, out_data, out_ctrl} = h_q;

  assign out_valid    = (state_q != ST_EMPTY);
  assign out_rf_write = out_valid & h_q[RFW_BIT];
  assign dbg_state    = state_q;

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready & ~stall;

  // Ready generation: the skid variant never looks at out_ready, so there
  // is no combinational path from downstream back to upstream.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != ST_TWO) & ~stall;
    end else begin : g_pass_ready
      assign in_ready = (~out_valid | out_ready) & ~stall;
    end
  endgenerate

  // Occupancy FSM and payload movement. stall needs no branch of its own:
  // it forces accept and retire low, which freezes everything. In the
  // single-entry variant an accept from ONE always coincides with a retire,
  // so TWO is never entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            h_q     <= in_beat;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            h_q <= in_beat;
          end else if (accept) begin
            s_q     <= in_beat;
            state_q <= ST_TWO;
          end else if (retire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (retire) begin
            h_q     <= s_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!stall && !out_valid && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule
